// File: rtl/voice_mixer_pkg.sv
// Shared audio definitions for the voice mixer and related blocks:
// sample/sum widths, saturation limits, FSM encoding and small helpers.
package voice_mixer_pkg;

  localparam int SAMPLE_W           = 18;
  localparam int NUM_VOICES         = 3;
  localparam int SUM_W              = SAMPLE_W + 2;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  // Clamp limits expressed at the wide sum width so they compare directly
  // against a shifted sum.
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SUM     = 2'd2,
    ST_SAT     = 2'd3
  } mix_state_e;

  // Sign-extend one voice sample to the accumulator width.
  function automatic logic signed [SUM_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
    return {{(SUM_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

  // Attenuation codes above 2 collapse to 2.
  function automatic logic [1:0] gain_clamp(input logic [1:0] g);
    return (g == 2'd3) ? 2'd2 : g;
  endfunction

endpackage

// File: rtl/voice_mixer_sat_shift.sv
// Combinational attenuation and saturation: arithmetic right shift of a
// wide sum, then clamp to the sample range with a clip indication.
module voice_mixer_sat_shift
  import voice_mixer_pkg::*;
(
  input  logic signed [SUM_W-1:0]    sum_i,
  input  logic        [1:0]          shift_i,
  output logic        [SAMPLE_W-1:0] sample_o,
  output logic                       clip_o
);

  logic        [1:0]       shamt_s;
  logic signed [SUM_W-1:0] shifted_s;

  assign shamt_s   = gain_clamp(shift_i);
  assign shifted_s = sum_i >>> shamt_s;

  // Clamp the attenuated sum into the signed sample range.
  always_comb begin
    sample_o = shifted_s[SAMPLE_W-1:0];
    clip_o   = 1'b0;
    if (shifted_s > SAT_MAX) begin
      sample_o = SAT_MAX[SAMPLE_W-1:0];
      clip_o   = 1'b1;
    end else if (shifted_s < SAT_MIN) begin
      sample_o = SAT_MIN[SAMPLE_W-1:0];
      clip_o   = 1'b1;
    end else begin
      sample_o = shifted_s[SAMPLE_W-1:0];
      clip_o   = 1'b0;
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Three-voice mixer: on a codec request collects one sample per enabled
// voice (voices answer in any cycle), sums, attenuates, saturates and
// presents the result with a one-cycle ready pulse.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic                generate_next_sample,
  input  logic [SAMPLE_W-1:0] sample_in1,
  input  logic [SAMPLE_W-1:0] sample_in2,
  input  logic [SAMPLE_W-1:0] sample_in3,
  input  logic                sample_ready1,
  input  logic                sample_ready2,
  input  logic                sample_ready3,
  input  logic [2:0]          voice_mask,
  input  logic [1:0]          gain_shift,
  input  logic                clear_flags,
  output logic [SAMPLE_W-1:0] mix_out,
  output logic                mix_ready,
  output logic                clip_flag,
  output logic                timeout_flag,
  output logic                overrun_flag
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

  mix_state_e state_q, state_d;

  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] hold_q, hold_d;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] smp_s;
  logic [NUM_VOICES-1:0]               rdy_s;
  logic [NUM_VOICES-1:0]               cap_s;
  logic [NUM_VOICES-1:0]               got_next_s;
  logic [NUM_VOICES-1:0]               got_q, got_d;
  logic [2:0]                          mask_q, mask_d;
  logic [1:0]                          gain_q, gain_d;
  logic [TIMER_W-1:0]                  timer_q, timer_d;
  logic signed [SUM_W-1:0]             sum_q, sum_d;
  logic signed [SUM_W-1:0]             sum_acc_s;
  logic [SAMPLE_W-1:0]                 mix_out_q, mix_out_d;
  logic                                mix_ready_q, mix_ready_d;
  logic                                clip_flag_q, clip_flag_d;
  logic                                timeout_flag_q, timeout_flag_d;
  logic                                overrun_flag_q, overrun_flag_d;
  logic                                clip_set_s;
  logic                                timeout_set_s;
  logic                                overrun_set_s;
  logic [SAMPLE_W-1:0]                 sat_sample_s;
  logic                                sat_clip_s;

  assign smp_s = {sample_in3, sample_in2, sample_in1};
  assign rdy_s = {sample_ready3, sample_ready2, sample_ready1};

  // First ready from each voice wins; later pulses from that voice are dropped.
  assign cap_s      = rdy_s & ~got_q;
  assign got_next_s = got_q | cap_s;

  // A request while a mix is in flight is dropped and remembered as overrun.
  assign overrun_set_s = generate_next_sample && (state_q != ST_IDLE);

  voice_mixer_sat_shift u_sat_shift (
    .sum_i    (sum_q),
    .shift_i  (gain_q),
    .sample_o (sat_sample_s),
    .clip_o   (sat_clip_s)
  );

  // Accumulate only voices that are both enabled and actually delivered.
  always_comb begin
    sum_acc_s = {SUM_W{1'b0}};
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (got_q[i] && mask_q[i]) begin
        sum_acc_s = sum_acc_s + sext_sample(hold_q[i]);
      end else begin
        sum_acc_s = sum_acc_s;
      end
    end
  end

  // Next-state and datapath control for the collect/sum/saturate sequence.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    got_d         = got_q;
    mask_d        = mask_q;
    gain_d        = gain_q;
    timer_d       = timer_q;
    sum_d         = sum_q;
    mix_out_d     = mix_out_q;
    mix_ready_d   = 1'b0;
    clip_set_s    = 1'b0;
    timeout_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (generate_next_sample) begin
          if (play_enable) begin
            mask_d  = voice_mask;
            gain_d  = gain_shift;
            got_d   = {NUM_VOICES{1'b0}};
            timer_d = TIMER_LOAD;
            state_d = ST_COLLECT;
          end else begin
            // Silence: skip collection and push a zero sum straight out.
            sum_d   = {SUM_W{1'b0}};
            state_d = ST_SAT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (cap_s[i]) begin
            hold_d[i] = smp_s[i];
          end else begin
            hold_d[i] = hold_q[i];
          end
        end
        got_d = got_next_s;
        if ((got_next_s | ~mask_q) == 3'b111) begin
          state_d = ST_SUM;
        end else if (timer_q == {TIMER_W{1'b0}}) begin
          timeout_set_s = 1'b1;
          state_d       = ST_SUM;
        end else begin
          timer_d = timer_q - {{(TIMER_W-1){1'b0}}, 1'b1};
          state_d = ST_COLLECT;
        end
      end
      ST_SUM: begin
        sum_d   = sum_acc_s;
        state_d = ST_SAT;
      end
      ST_SAT: begin
        mix_out_d   = sat_sample_s;
        mix_ready_d = 1'b1;
        clip_set_s  = sat_clip_s;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky flags: a set event in the same cycle as a clear takes priority.
  always_comb begin
    clip_flag_d    = clip_set_s    | (clip_flag_q    & ~clear_flags);
    timeout_flag_d = timeout_set_s | (timeout_flag_q & ~clear_flags);
    overrun_flag_d = overrun_set_s | (overrun_flag_q & ~clear_flags);
  end

  // State and datapath registers; reset abandons any mix in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      hold_q         <= '0;
      got_q          <= {NUM_VOICES{1'b0}};
      mask_q         <= 3'b000;
      gain_q         <= 2'b00;
      timer_q        <= {TIMER_W{1'b0}};
      sum_q          <= {SUM_W{1'b0}};
      mix_out_q      <= {SAMPLE_W{1'b0}};
      mix_ready_q    <= 1'b0;
      clip_flag_q    <= 1'b0;
      timeout_flag_q <= 1'b0;
      overrun_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      got_q          <= got_d;
      mask_q         <= mask_d;
      gain_q         <= gain_d;
      timer_q        <= timer_d;
      sum_q          <= sum_d;
      mix_out_q      <= mix_out_d;
      mix_ready_q    <= mix_ready_d;
      clip_flag_q    <= clip_flag_d;
      timeout_flag_q <= timeout_flag_d;
      overrun_flag_q <= overrun_flag_d;
    end
  end

  assign mix_out      = mix_out_q;
  assign mix_ready    = mix_ready_q;
  assign clip_flag    = clip_flag_q;
  assign timeout_flag = timeout_flag_q;
  assign overrun_flag = overrun_flag_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer with hand-computed expected results.
module tb_voice_mixer;
  import voice_mixer_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                play_enable;
  logic                generate_next_sample;
  logic [SAMPLE_W-1:0] sample_in1, sample_in2, sample_in3;
  logic                sample_ready1, sample_ready2, sample_ready3;
  logic [2:0]          voice_mask;
  logic [1:0]          gain_shift;
  logic                clear_flags;
  logic [SAMPLE_W-1:0] mix_out;
  logic                mix_ready;
  logic                clip_flag, timeout_flag, overrun_flag;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat;
  int seen;

  voice_mixer dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .generate_next_sample (generate_next_sample),
    .sample_in1           (sample_in1),
    .sample_in2           (sample_in2),
    .sample_in3           (sample_in3),
    .sample_ready1        (sample_ready1),
    .sample_ready2        (sample_ready2),
    .sample_ready3        (sample_ready3),
    .voice_mask           (voice_mask),
    .gain_shift           (gain_shift),
    .clear_flags          (clear_flags),
    .mix_out              (mix_out),
    .mix_ready            (mix_ready),
    .clip_flag            (clip_flag),
    .timeout_flag         (timeout_flag),
    .overrun_flag         (overrun_flag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the bench lives 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int mix_val();
    return int'($signed(mix_out));
  endfunction

  task automatic set_rdy(input int v, input int val);
    case (v)
      1: begin sample_in1 = SAMPLE_W'(val); sample_ready1 = 1'b1; end
      2: begin sample_in2 = SAMPLE_W'(val); sample_ready2 = 1'b1; end
      3: begin sample_in3 = SAMPLE_W'(val); sample_ready3 = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic clr_rdy();
    sample_ready1 = 1'b0;
    sample_ready2 = 1'b0;
    sample_ready3 = 1'b0;
  endtask

  task automatic pulse(input int v, input int val);
    set_rdy(v, val);
    tick();
    clr_rdy();
  endtask

  // Request in cycle 0; returns in cycle 1.
  task automatic req(input logic [2:0] m, input logic [1:0] g);
    voice_mask           = m;
    gain_shift           = g;
    generate_next_sample = 1'b1;
    cyc = 0;
    tick();
    generate_next_sample = 1'b0;
  endtask

  // Wait (bounded) for mix_ready; reports the cycle it was seen in.
  task automatic wait_mix(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (mix_ready) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) check_eq({tag, "_no_ready"}, 0, 1);
  endtask

  task automatic scen_basic(input string tag);
    req(3'b111, 2'd0);
    tick();                 // cycle 2
    pulse(1, 1000);         // cycle 2 -> 3
    tick(); tick();         // cycle 5
    pulse(3, -300);         // cycle 5 -> 6
    tick();                 // cycle 7
    pulse(2, 50);           // cycle 7 -> 8
    wait_mix(tag, lat);
    check_eq({tag, "_lat"}, lat, 10);
    check_eq({tag, "_out"}, mix_val(), 750);
    check_eq({tag, "_clip"}, int'(clip_flag), 0);
    check_eq({tag, "_tmo"}, int'(timeout_flag), 0);
    check_eq({tag, "_ovr"}, int'(overrun_flag), 0);
    tick();
    check_eq({tag, "_pulse1"}, int'(mix_ready), 0);
  endtask

  initial begin
    reset = 1'b0; play_enable = 1'b1; generate_next_sample = 1'b0;
    sample_in1 = '0; sample_in2 = '0; sample_in3 = '0;
    clr_rdy(); voice_mask = 3'b111; gain_shift = 2'd0; clear_flags = 1'b0;
    #23;
    check_eq("rst_out", mix_val(), 0);
    check_eq("rst_ready", int'(mix_ready), 0);
    check_eq("rst_flags", int'({clip_flag, timeout_flag, overrun_flag}), 0);
    reset = 1'b1;
    tick(); tick();

    scen_basic("basic");

    // Positive saturation, all voices in one cycle.
    req(3'b111, 2'd0);
    set_rdy(1, 131071); set_rdy(2, 131071); set_rdy(3, 131071);
    tick(); clr_rdy();
    wait_mix("satp", lat);
    check_eq("satp_lat", lat, 4);
    check_eq("satp_out", mix_val(), 131071);
    check_eq("satp_clip", int'(clip_flag), 1);
    tick();

    // Negative saturation.
    req(3'b111, 2'd0);
    set_rdy(1, -131072); set_rdy(2, -131072); set_rdy(3, -131072);
    tick(); clr_rdy();
    wait_mix("satn", lat);
    check_eq("satn_out", mix_val(), -131072);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    check_eq("clip_cleared", int'(clip_flag), 0);

    // Second ready from an already-captured voice is ignored.
    req(3'b011, 2'd0);
    pulse(1, 500);
    pulse(1, 9999);
    pulse(2, 100);
    wait_mix("dup", lat);
    check_eq("dup_lat", lat, 6);
    check_eq("dup_out", mix_val(), 600);
    tick();

    // Empty mask exits collection immediately.
    req(3'b000, 2'd0);
    wait_mix("m000", lat);
    check_eq("m000_lat", lat, 4);
    check_eq("m000_out", mix_val(), 0);
    tick();

    // Gain code 3 behaves like 2.
    req(3'b001, 2'd3);
    pulse(1, 4000);
    wait_mix("g3", lat);
    check_eq("g3_out", mix_val(), 1000);
    tick();

    // Mask 101, gain 1: voice 2 is never asked for.
    req(3'b101, 2'd1);
    pulse(1, 4000);
    tick();
    pulse(3, 2000);
    wait_mix("m101", lat);
    check_eq("m101_lat", lat, 6);
    check_eq("m101_out", mix_val(), 3000);
    check_eq("m101_tmo", int'(timeout_flag), 0);
    tick();

    // Voice 3 never answers: timeout after the full budget.
    req(3'b111, 2'd0);
    pulse(1, 100);
    pulse(2, 200);
    wait_mix("tmo", lat);
    check_eq("tmo_lat", lat, 67);
    check_eq("tmo_out", mix_val(), 300);
    check_eq("tmo_flag", int'(timeout_flag), 1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    check_eq("tmo_cleared", int'(timeout_flag), 0);

    // Play disabled: silent result two cycles after request.
    play_enable = 1'b0;
    req(3'b111, 2'd0);
    wait_mix("mute", lat);
    check_eq("mute_lat", lat, 2);
    check_eq("mute_out", mix_val(), 0);
    play_enable = 1'b1;
    tick();

    // Request while collecting sets overrun; play_enable drop is harmless.
    req(3'b111, 2'd0);
    pulse(1, 10);
    generate_next_sample = 1'b1; play_enable = 1'b0;
    tick();
    generate_next_sample = 1'b0;
    set_rdy(2, 20); set_rdy(3, 30);
    tick(); clr_rdy();
    wait_mix("ovr", lat);
    check_eq("ovr_lat", lat, 6);
    check_eq("ovr_out", mix_val(), 60);
    check_eq("ovr_flag", int'(overrun_flag), 1);
    play_enable = 1'b1;
    tick();

    // Reset during collection after two captures.
    req(3'b111, 2'd0);
    pulse(1, 1000);
    pulse(2, 50);
    #2; reset = 1'b0; #1;
    check_eq("arst_out", mix_val(), 0);
    check_eq("arst_flags", int'({clip_flag, timeout_flag, overrun_flag}), 0);
    check_eq("arst_ready", int'(mix_ready), 0);
    #3; reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mix_ready) seen++;
    end
    check_eq("arst_no_ready", seen, 0);

    scen_basic("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Sits directly downstream of the three-voice note player and upstream of the codec interface.
- On each codec sample request, collects one sample from every unmuted voice; voices may answer in different cycles.
- Sums the collected samples, applies a power-of-two attenuation and saturates the result to the codec sample width.
- Presents one mixed sample with a single-cycle ready pulse.

Parameters:
- SAMPLE_W, 18: width of each voice sample and of the mixed output (two's complement).
- NUM_VOICES, 3: number of voice inputs; the RTL supports exactly 3.
- TIMEOUT_CYCLES, 64: maximum cycles spent collecting before missing voices are forced to zero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play_enable  in  1  high = mixing active; low = output silence
- generate_next_sample  in  1  codec request pulse, 1 cycle
- sample_in1  in  SAMPLE_W  voice 1 sample, signed
- sample_in2  in  SAMPLE_W  voice 2 sample, signed
- sample_in3  in  SAMPLE_W  voice 3 sample, signed
- sample_ready1  in  1  voice 1 sample valid, 1-cycle pulse
- sample_ready2  in  1  voice 2 sample valid, 1-cycle pulse
- sample_ready3  in  1  voice 3 sample valid, 1-cycle pulse
- voice_mask  in  3  bit i high = voice i+1 participates; sampled at request
- gain_shift  in  2  arithmetic right shift applied to sum (0..2; value 3 treated as 2); sampled at request
- clear_flags  in  1  synchronous clear of sticky flags
- mix_out  out  SAMPLE_W  mixed sample, signed, held until next result
- mix_ready  out  1  1-cycle pulse, mix_out valid
- clip_flag  out  1  sticky: a result saturated
- timeout_flag  out  1  sticky: collection timed out
- overrun_flag  out  1  sticky: request arrived while busy

Behaviour:
Reset (reset low, asynchronous):
- FSM goes to IDLE.
- mix_out, mix_ready, all flags, holding registers, got bits and timer clear to 0.
- Reset asserted mid-operation abandons the mix; no mix_ready is produced.

FSM states: IDLE, COLLECT, SUM, SAT.
- IDLE: on generate_next_sample:
  - play_enable=1: latch voice_mask and gain_shift, clear got[2:0], load timer = TIMEOUT_CYCLES-1, go to COLLECT.
  - play_enable=0: go directly to SAT with a zero sum; mix_out=0 and mix_ready pulse 2 cycles after the request.
- COLLECT, each cycle:
  - For each voice with sample_readyi=1 and its got bit clear, capture sample_ini into hold_i and set got_i.
  - A second ready from an already-captured voice is ignored.
  - Exit to SUM when (got | ~mask_latched) == 3'b111. This includes a pulse arriving in the same cycle the condition becomes true.
  - Mask 3'b000 exits to SUM on the cycle after entry.
  - Timer decrements each cycle. At 0 with voices still missing: missing voices contribute 0, timeout_flag sets, go to SUM.
- SUM: sign-extend each participating hold to SAMPLE_W+2 bits; masked or missing voices contribute 0. Register the 20-bit sum, go to SAT.
- SAT:
  - Arithmetic right shift by the latched gain_shift, then clamp to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. Clamping sets clip_flag.
  - Register mix_out and pulse mix_ready for exactly 1 cycle, return to IDLE.
- Latency: the last required sample_ready captured in cycle N gives mix_ready in cycle N+3.
- generate_next_sample while not in IDLE: ignored, overrun_flag sets, the in-flight mix is unaffected.
- play_enable falling during COLLECT: the mix completes normally with the samples captured so far.
- clear_flags clears all sticky flags. If a set event occurs in the same cycle, the set wins.

Decomposition:
- Shared audio package: SAMPLE_W, NUM_VOICES, SUM_W = SAMPLE_W+2, saturation limit constants and the FSM state encoding.
- One natural sub-module, sat_shift: combinational arithmetic shift plus clamp plus clip indication, reusable by future mixers.

Test Plan:
- Mask 111, gain 0; ready pulses 1,3,2 on cycles 2,5,7 with samples 1000, -300, 50 → mix_out=750, mix_ready on cycle 10, no flags.
- Mask 111, gain 0; all three samples = 131071 in the same cycle → mix_out=131071, clip_flag=1. Then three samples of -131072 → mix_out=-131072.
- Mask 101, gain 1; samples 4000, (voice 2 never ready), 2000 → mix_out=3000, timeout_flag=0.
- Mask 111; voice 3 never ready, TIMEOUT_CYCLES=64 → mix_ready 66 cycles after entering COLLECT, sum excludes voice 3, timeout_flag=1. Then clear_flags → timeout_flag=0.
- Request with play_enable=0 → mix_out=0, mix_ready 2 cycles later. A second request during COLLECT → overrun_flag=1, result unchanged.
- Reset pulled low in COLLECT after 2 captures → all outputs 0 immediately. After release, a fresh request behaves as in the first scenario.
